mem_arbiter: RTL and testbench

//   Shares the single physical memory port between the instruction-fetch requester (I) and the

---
 rtl/lc3b_types.sv | 30 +++
 rtl/mem_arb_mux.sv | 27 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// LC-3b shared types: memory words, write masks and the
// memory arbiter's state, grant and request bundle.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE_I,
    S_SERVE_D,
    S_RELEASE
  } lc3b_arb_state;

  typedef enum logic {
    ARB_I,
    ARB_D
  } lc3b_arb_grant;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask byte_enable;
  } lc3b_mem_req_t;

  localparam lc3b_mem_wmask MASK_ALL = 2'b11;

endpackage

// File: rtl/mem_arb_mux.sv
// 2:1 steering of a memory request bundle by grant; idle
// output is a quiet port with a full byte mask.
module mem_arb_mux
  import lc3b_types::*;
(
  input  lc3b_mem_req_t i_req,
  input  lc3b_mem_req_t d_req,
  input  lc3b_arb_grant grant,
  input  logic          en,
  output lc3b_mem_req_t mem_req
);

  lc3b_mem_req_t sel;

  assign sel = (grant == ARB_I) ? i_req : d_req;

  always_comb begin
    mem_req             = '0;
    mem_req.byte_enable = MASK_ALL;
    if (en) begin
      mem_req = sel;
      // read+write together is illegal; the write wins
      mem_req.read = sel.read & ~sel.write;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// I/D memory port arbiter, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie breaking.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read,
  input  logic          i_write,
  input  lc3b_word      i_address,
  input  lc3b_word      i_wdata,
  input  lc3b_mem_wmask i_byte_enable,
  output lc3b_word      i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_byte_enable,
  output lc3b_word      d_rdata,
  output logic          d_resp,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_rdata,
  input  logic          mem_resp,
  output logic          busy
);

  lc3b_arb_state state, state_d;
  lc3b_arb_grant grant;
  lc3b_mem_req_t i_req, d_req, m_req;
  logic req_i, req_d, tie, tie_to_i;
  logic grant_i, grant_d, serve;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;
  assign tie   = req_i & req_d;

`ifdef MEM_ARB_RR_EN
  lc3b_arb_grant last_grant;

  assign tie_to_i = (last_grant == ARB_D);

  always_ff @(posedge clk) begin
    if (rst)          last_grant <= ARB_D;
    else if (grant_i) last_grant <= ARB_I;
    else if (grant_d) last_grant <= ARB_D;
  end
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  assign tie_to_i = (starve_cnt == LIM);

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (grant_i)
      starve_cnt <= '0;
    else if (grant_d && tie && starve_cnt != LIM)
      starve_cnt <= starve_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state)
      S_IDLE: begin
        grant_i = req_i & (~req_d | tie_to_i);
        grant_d = req_d & ~grant_i;
        if (grant_i)      state_d = S_SERVE_I;
        else if (grant_d) state_d = S_SERVE_D;
      end
      S_SERVE_I,
      S_SERVE_D: if (mem_resp) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
    endcase
  end

  assign serve = (state == S_SERVE_I) |
                 (state == S_SERVE_D);
  assign grant = (state == S_SERVE_I) ? ARB_I : ARB_D;

  assign i_req = '{read: i_read, write: i_write,
                   address: i_address, wdata: i_wdata,
                   byte_enable: i_byte_enable};
  assign d_req = '{read: d_read, write: d_write,
                   address: d_address, wdata: d_wdata,
                   byte_enable: d_byte_enable};

  mem_arb_mux u_mux (
    .i_req   (i_req),
    .d_req   (d_req),
    .grant   (grant),
    .en      (serve),
    .mem_req (m_req)
  );

  assign mem_read        = m_req.read;
  assign mem_write       = m_req.write;
  assign mem_address     = m_req.address;
  assign mem_wdata       = m_req.wdata;
  assign mem_byte_enable = m_req.byte_enable;

  assign busy    = serve;
  assign i_resp  = (state == S_SERVE_I) & mem_resp;
  assign d_resp  = (state == S_SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_read && i_write))
        else $warning("mem_arbiter: i_read and i_write both high");
      assert (!(d_read && d_write))
        else $warning("mem_arbiter: d_read and d_write both high");
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-
// programmable memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic i_read, i_write, d_read, d_write;
  logic [15:0] i_address, i_wdata, d_address, d_wdata;
  logic [1:0] i_byte_enable, d_byte_enable;
  logic [15:0] i_rdata, d_rdata;
  logic i_resp, d_resp;
  logic mem_read, mem_write, mem_resp, busy;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic [1:0] mem_byte_enable;

  logic model_resp, inj_resp;
  int lat, mcnt;

  int pass_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    bit side;
    bit rd;
    bit wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0] be;
  } txn_t;

  txn_t exp_q[$];
  txn_t rsp_q[$];

  always #5 clk = ~clk;

  assign mem_resp = model_resp | inj_resp;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write),
    .i_address(i_address), .i_wdata(i_wdata),
    .i_byte_enable(i_byte_enable),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write),
    .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy)
  );

  // memory answers lat cycles after the strobe is first seen
  always @(posedge clk) begin
    if (rst) begin
      model_resp <= 1'b0;
      mcnt <= 0;
      mem_rdata <= 16'h0;
    end else if ((mem_read | mem_write) && !model_resp) begin
      if (mcnt >= lat - 1) begin
        model_resp <= 1'b1;
        mcnt <= 0;
        mem_rdata <= mem_address ^ 16'hA5A5;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      model_resp <= 1'b0;
      if (!(mem_read | mem_write)) mcnt <= 0;
    end
  end

  bit prev_strobe = 1'b0;

  always @(negedge clk) begin
    txn_t e;
    txn_t r;
    bit strobe;
    logic [15:0] rd_got;
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      strobe = mem_read | mem_write;
      chk_cnt++;
      if (mem_read && mem_write)
        $display("FAIL sb_both_strobes: got rd=%b wr=%b want not both",
                 mem_read, mem_write);
      else pass_cnt++;
      if (strobe && !prev_strobe) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_req_unexpected: got addr %h want none",
                   mem_address);
        end else begin
          e = exp_q.pop_front();
          if ({mem_read, mem_write, mem_address, mem_wdata,
               mem_byte_enable} !==
              {e.rd, e.wr, e.addr, e.wdata, e.be})
            $display("FAIL sb_req: got r%b w%b a%h d%h m%b want r%b w%b a%h d%h m%b",
                     mem_read, mem_write, mem_address, mem_wdata,
                     mem_byte_enable, e.rd, e.wr, e.addr, e.wdata, e.be);
          else pass_cnt++;
          rsp_q.push_back(e);
        end
      end
      if (i_resp || d_resp) begin
        chk_cnt++;
        if (rsp_q.size() == 0) begin
          $display("FAIL sb_resp_unexpected: got i%b d%b want none",
                   i_resp, d_resp);
        end else begin
          r = rsp_q.pop_front();
          if ({i_resp, d_resp} !== (r.side ? 2'b01 : 2'b10))
            $display("FAIL sb_resp_side: got i%b d%b want side %s",
                     i_resp, d_resp, r.side ? "D" : "I");
          else pass_cnt++;
          if (r.rd) begin
            rd_got = r.side ? d_rdata : i_rdata;
            chk_cnt++;
            if (rd_got !== (r.addr ^ 16'hA5A5))
              $display("FAIL sb_rdata: got %h want %h",
                       rd_got, r.addr ^ 16'hA5A5);
            else pass_cnt++;
          end
        end
      end
      prev_strobe = strobe;
    end
  end

  function automatic void push(bit side, bit rd, bit wr,
                               logic [15:0] a, logic [15:0] w,
                               logic [1:0] be);
    txn_t t;
    t.side = side; t.rd = rd; t.wr = wr;
    t.addr = a; t.wdata = w; t.be = be;
    exp_q.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_address = 0; i_wdata = 0; i_byte_enable = 2'b11;
    d_address = 0; d_wdata = 0; d_byte_enable = 2'b11;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    inj_resp = 0;
    lat = 1;
    rst = 1'b1;
    i_read = 1; d_read = 1;
    i_address = 16'h1111; d_address = 16'h2222;
    tick();
    tick();
    chk_cnt++;
    if ({mem_read, mem_write, i_resp, d_resp, busy} !== 5'b0)
      $display("FAIL rst_strobes: got %b want 00000",
               {mem_read, mem_write, i_resp, d_resp, busy});
    else pass_cnt++;
    chk_cnt++;
    if ({mem_address, mem_wdata, mem_byte_enable} !== {32'h0, 2'b11})
      $display("FAIL rst_mem_bus: got a%h d%h m%b want a0000 d0000 m11",
               mem_address, mem_wdata, mem_byte_enable);
    else pass_cnt++;
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_i_read();
    int cyc;
    int d_seen;
    lat = 3;
    d_seen = 0;
    push(0, 1, 0, 16'h0040, 16'h0, 2'b11);
    i_read = 1; i_address = 16'h0040;
    chk_cnt++;
    if (mem_read !== 1'b0)
      $display("FAIL i_rd_registered: got %b want 0", mem_read);
    else pass_cnt++;
    for (cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (d_resp) d_seen++;
      if (cyc == 1) begin
        chk_cnt++;
        if ({mem_read, busy} !== 2'b11)
          $display("FAIL i_rd_start: got rd%b busy%b want 11",
                   mem_read, busy);
        else pass_cnt++;
      end
      if (i_resp) break;
    end
    chk_cnt++;
    if (cyc !== 1 + lat)
      $display("FAIL i_rd_latency: got %0d want %0d", cyc, 1 + lat);
    else pass_cnt++;
    chk_cnt++;
    if (d_seen !== 0)
      $display("FAIL i_rd_no_dresp: got %0d want 0", d_seen);
    else pass_cnt++;
    idle_inputs();
    tick();
    chk_cnt++;
    if ({busy, mem_read, i_resp} !== 3'b000)
      $display("FAIL i_rd_release: got %b want 000",
               {busy, mem_read, i_resp});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_d_write();
    int nresp;
    lat = 2;
    nresp = 0;
    push(1, 0, 1, 16'h0100, 16'h1234, 2'b01);
    d_write = 1; d_address = 16'h0100;
    d_wdata = 16'h1234; d_byte_enable = 2'b01;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        chk_cnt++;
        if ({mem_write, mem_wdata, mem_byte_enable} !==
            {1'b1, 16'h1234, 2'b01})
          $display("FAIL d_wr_bus: got w%b d%h m%b want w1 d1234 m01",
                   mem_write, mem_wdata, mem_byte_enable);
        else pass_cnt++;
      end
      if (d_resp) begin
        nresp++;
        idle_inputs();
      end
    end
    chk_cnt++;
    if (nresp !== 1)
      $display("FAIL d_wr_resp_count: got %0d want 1", nresp);
    else pass_cnt++;
  endtask

  task automatic test_tie_fixed();
    int ni, nd;
    bit first_d, got_first;
    lat = 2;
    ni = 0; nd = 0; got_first = 0; first_d = 0;
    push(1, 1, 0, 16'h0300, 16'h0, 2'b11);
    push(0, 1, 0, 16'h0200, 16'h0, 2'b11);
    i_read = 1; i_address = 16'h0200;
    d_read = 1; d_address = 16'h0300;
    for (int c = 0; c < 30; c++) begin
      tick();
      if ((i_resp || d_resp) && !got_first) begin
        got_first = 1;
        first_d = d_resp;
      end
      if (d_resp) begin nd++; d_read = 0; end
      if (i_resp) begin ni++; i_read = 0; end
    end
    chk_cnt++;
    if (!(got_first && first_d))
      $display("FAIL tie_first: got seen%b d%b want seen1 d1",
               got_first, first_d);
    else pass_cnt++;
    chk_cnt++;
    if ({ni, nd} !== {32'd1, 32'd1})
      $display("FAIL tie_counts: got i%0d d%0d want i1 d1", ni, nd);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_starvation();
    bit want_d[10];
    bit got_d[10];
    int sc, n;
    pulse_reset();
    lat = 1;
    sc = 0;
    for (int k = 0; k < 10; k++) begin
      if (sc == 4) begin want_d[k] = 0; sc = 0; end
      else begin want_d[k] = 1; sc++; end
      if (want_d[k]) push(1, 1, 0, 16'h0300, 16'h0, 2'b11);
      else           push(0, 1, 0, 16'h0200, 16'h0, 2'b11);
    end
    i_read = 1; i_address = 16'h0200;
    d_read = 1; d_address = 16'h0300;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      tick();
      if (i_resp || d_resp) begin
        got_d[n] = d_resp;
        n++;
        if (n == 10) idle_inputs();
      end
    end
    idle_inputs();
    chk_cnt++;
    if (n !== 10)
      $display("FAIL starve_timeout: got %0d grants want 10", n);
    else pass_cnt++;
    for (int k = 0; k < n; k++) begin
      chk_cnt++;
      if (got_d[k] !== want_d[k])
        $display("FAIL starve_order[%0d]: got %s want %s", k,
                 got_d[k] ? "D" : "I", want_d[k] ? "D" : "I");
      else pass_cnt++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    lat = 6;
    seen = 0;
    push(1, 1, 0, 16'h0500, 16'h0, 2'b11);
    d_read = 1; d_address = 16'h0500;
    tick();
    tick();
    tick();
    chk_cnt++;
    if ({mem_read, busy} !== 2'b11)
      $display("FAIL abort_pre: got rd%b busy%b want 11",
               mem_read, busy);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    chk_cnt++;
    if ({mem_read, busy} !== 2'b00)
      $display("FAIL abort_post: got rd%b busy%b want 00",
               mem_read, busy);
    else pass_cnt++;
    rst = 1'b0;
    idle_inputs();
    rsp_q.delete();
    inj_resp = 1;
    tick();
    if (i_resp || d_resp) seen++;
    inj_resp = 0;
    tick();
    chk_cnt++;
    if (seen !== 0)
      $display("FAIL abort_late_resp: got %0d resps want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_idle_resp();
    inj_resp = 1;
    tick();
    chk_cnt++;
    if ({i_resp, d_resp, busy} !== 3'b000)
      $display("FAIL idle_resp: got %b want 000",
               {i_resp, d_resp, busy});
    else pass_cnt++;
    inj_resp = 0;
    tick();
  endtask

  task automatic test_illegal_rw();
    int nresp;
    lat = 2;
    nresp = 0;
    push(1, 0, 1, 16'h0600, 16'hBEEF, 2'b11);
    d_read = 1; d_write = 1;
    d_address = 16'h0600; d_wdata = 16'hBEEF;
    tick();
    chk_cnt++;
    if ({mem_read, mem_write} !== 2'b01)
      $display("FAIL illegal_rw: got rd%b wr%b want rd0 wr1",
               mem_read, mem_write);
    else pass_cnt++;
    for (int c = 0; c < 10; c++) begin
      if (d_resp) begin nresp++; idle_inputs(); end
      tick();
    end
    chk_cnt++;
    if (nresp !== 1)
      $display("FAIL illegal_rw_resp: got %0d want 1", nresp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_tie_fixed();
    test_starvation();
    test_reset_abort();
    test_idle_resp();
    test_illegal_rw();
    tick();
    chk_cnt++;
    if (exp_q.size() + rsp_q.size() !== 0)
      $display("FAIL sb_drain: got %0d pending want 0",
               exp_q.size() + rsp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
